// File: rtl/alu_unit.sv
// alu_unit: 32-bit registered ALU (ADD/SUB/AND/OR/XOR/SLT, optional SLL/SRL) with z/c/v flags.
// Latency: one clk; operands captured on a rising edge with en=1 appear right after that edge.
// Backpressure: en=0 stalls the stage and the outputs hold. Define ALU_SHIFT_EN to add the shifter.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;
  localparam int         SHW    = $clog2(WIDTH);
`endif

  logic [WIDTH-1:0] res_d, res_q;
  logic             z_d, z_q;
  logic             c_d, c_q;
  logic             v_d, v_q;

  // Shared adder: SUB reuses it as A + ~B + 1 so carry-out means "no borrow".
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic             slt;

`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sll_ext;
  logic [WIDTH:0]   srl_ext;
`endif

  // Adder operand conditioning and signed compare for SLT.
  always_comb begin
    is_sub  = (sel == OP_SUB);
    add_b   = is_sub ? ~opB : opB;
    add_sum = {1'b0, opA} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
    slt     = ($signed(opA) < $signed(opB));
  end

`ifdef ALU_SHIFT_EN
  // One extra bit on the shifted-out side catches the last bit lost; a zero shift leaves it 0.
  always_comb begin
    shamt   = opB[SHW-1:0];
    sll_ext = {1'b0, opA} << shamt;
    srl_ext = {opA, 1'b0} >> shamt;
  end
`endif

  // Next-state result and flags as a pure function of the operands and select.
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (sel)
      OP_ADD: begin
        res_d = add_sum[WIDTH-1:0];
        c_d   = add_sum[WIDTH];
        v_d   = (opA[WIDTH-1] == opB[WIDTH-1]) && (add_sum[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = add_sum[WIDTH-1:0];
        c_d   = add_sum[WIDTH];
        v_d   = (opA[WIDTH-1] != opB[WIDTH-1]) && (add_sum[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND: res_d = opA & opB;
      OP_OR:  res_d = opA | opB;
      OP_XOR: res_d = opA ^ opB;
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_SHIFT_EN
      OP_SLL: begin
        res_d = sll_ext[WIDTH-1:0];
        c_d   = sll_ext[WIDTH];
      end
      OP_SRL: begin
        res_d = srl_ext[WIDTH:1];
        c_d   = srl_ext[0];
      end
`endif
      default: begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
      end
    endcase
    z_d = (res_d == '0);
  end

  // Output registers: cleared asynchronously, loaded only when the stage is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (en) begin
      res_q <= res_d;
      z_q   <= z_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  assign res = res_q;
  assign z   = z_q;
  assign c   = c_q;
  assign v   = v_q;

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit: directed plan vectors, stall/reset cases and random traffic.
// Driver pushes the expected post-edge output into a queue; a monitor pops and compares after each edge.
// Build with +define+ALU_SHIFT_EN to exercise the shifter vectors.
module tb_alu_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [2:0]  sel;
  logic [31:0] res;
  logic        z;
  logic        c;
  logic        v;

  int checks;
  int passes;
  exp_t q[$];
  exp_t last_exp;

  alu_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .opA  (opA),
    .opB  (opB),
    .sel  (sel),
    .res  (res),
    .z    (z),
    .c    (c),
    .v    (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain wide-integer arithmetic.
  function automatic exp_t model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, r;
    longint unsigned ua, ub, us;
    int sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b[4:0]);
    case (s)
      3'd0: begin
        us    = ua + ub;
        e.res = us[31:0];
        e.c   = (us > 64'h0000_0000_FFFF_FFFF);
        r     = sa + sb;
        e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (ua >= ub);
        r     = sa - sb;
        e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'd6: begin
        e.res = a << sh;
        e.c   = (sh == 0) ? 1'b0 : a[32-sh];
      end
      3'd7: begin
        e.res = a >> sh;
        e.c   = (sh == 0) ? 1'b0 : a[sh-1];
      end
`endif
      default: e = '0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the expected output after the next edge.
  task automatic issue(input logic e_n, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] b, input bit use_given, input exp_t given);
    exp_t e;
    @(negedge clk);
    en  = e_n;
    sel = s;
    opA = a;
    opB = b;
    if (!e_n)          e = last_exp;
    else if (use_given) e = given;
    else               e = model(s, a, b);
    last_exp = e;
    q.push_back(e);
  endtask

  task automatic directed(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic cc, input logic vv);
    exp_t e;
    e.res = r;
    e.z   = (r == 32'd0);
    e.c   = cc;
    e.v   = vv;
    issue(1'b1, s, a, b, 1'b1, e);
  endtask

  task automatic check_now(input string name, input exp_t e);
    exp_t act;
    act = {res, z, c, v};
    checks++;
    if (act === e) passes++;
    else $display("FAIL %s: got res=%h z=%b c=%b v=%b, want res=%h z=%b c=%b v=%b",
                  name, act.res, act.z, act.c, act.v, e.res, e.z, e.c, e.v);
  endtask

  // Monitor: after every edge, compare the DUT output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_now("scoreboard", e);
      end
    end
  end

  initial begin
    exp_t zero_e;
    zero_e   = '0;
    checks   = 0;
    passes   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    en       = 1'b0;
    sel      = 3'd0;
    opA      = 32'hDEAD_BEEF;
    opB      = 32'h1234_5678;
    #2;
    check_now("reset_state", zero_e);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD
    directed(3'd0, 32'h9000_0000, 32'h9000_0000, 32'h2000_0000, 1'b1, 1'b1);
    directed(3'd0, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b1);
    directed(3'd0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0);
    // SUB
    directed(3'd1, 32'h8000_0000, 32'h7000_0000, 32'h1000_0000, 1'b1, 1'b1);
    directed(3'd1, 32'h0,         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    directed(3'd1, 32'd1,         32'd1,         32'd0,         1'b1, 1'b0);
    directed(3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0);
    // Logic / SLT
    directed(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    directed(3'd4, 32'hA5A5_1234, 32'hA5A5_1234, 32'h0,         1'b0, 1'b0);
    directed(3'd5, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0);
    directed(3'd5, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    directed(3'd6, 32'h8000_0001, 32'd1,         32'h0000_0002, 1'b1, 1'b0);
    directed(3'd7, 32'h0000_0003, 32'd1,         32'h0000_0001, 1'b1, 1'b0);
    directed(3'd6, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b0);
    directed(3'd7, 32'h8765_4321, 32'h0,         32'h8765_4321, 1'b0, 1'b0);
`else
    directed(3'd6, 32'h1234_5678, 32'd3,         32'h0,         1'b0, 1'b0);
    directed(3'd7, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0, 1'b0);
`endif
    // Leave a nonzero result, then stall with new operands: outputs must hold.
    directed(3'd1, 32'd6,         32'd1,         32'd5,         1'b1, 1'b0);
    issue(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, zero_e);
    issue(1'b0, 3'd3, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0, zero_e);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", zero_e);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = '0;
    issue(1'b0, 3'd0, 32'd7, 32'd8, 1'b0, zero_e);
    issue(1'b1, 3'd0, 32'd7, 32'd8, 1'b0, zero_e);

    // Random traffic, including random stalls.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ((i % 5) == 0) b = a;
      if ((i % 7) == 0) b = {$urandom_range(0, 1) == 1 ? 27'h7FF_FFFF : 27'h0, b[4:0]};
      issue(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b, 1'b0, zero_e);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
